// File: rtl/mmio_console_resp.sv
// Memory-mapped console/halt/cycle-count responder living beside D-SRAM on the core's data port.
// Optional feature: define MMIO_CYCLE_CNT_EN to build the 64-bit cycle counter and its high-word snapshot.
module mmio_console_resp #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_3F00,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_csn,
    input  logic        i_wen,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_di,
    output logic [31:0] o_dout,
    output logic        o_hit,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_halt,
    output logic [30:0] o_halt_code
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [2:0] OFF_TXDATA  = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_CYC_LO  = 3'd2;
    localparam logic [2:0] OFF_CYC_HI  = 3'd3;
    localparam logic [2:0] OFF_TOHOST  = 3'd4;
    localparam logic [2:0] OFF_SCRATCH = 3'd5;

    logic          w_sel;
    logic          w_wr;
    logic          w_rd;
    logic [2:0]    w_off;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_count8;
    logic [31:0]   w_status;
    logic [31:0]   w_tohost_nxt;
    logic [31:0]   w_scratch_nxt;
    logic [31:0]   w_cyc_lo;
    logic [31:0]   w_cyc_hi;
    logic [31:0]   w_rdata;
    logic          w_unused;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic [31:0]   r_tohost;
    logic [31:0]   r_scratch;
    logic          r_halt;
    logic [30:0]   r_halt_code;
    logic [31:0]   r_dout;
    logic          r_hit;

    function automatic logic [31:0] f_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // Address bits [1:0] are don't-care: the window is word-addressed.
    assign w_unused = &{1'b0, i_addr[1:0]};

    assign w_sel = !i_csn && (i_addr[31:5] == BASE_ADDR[31:5]);
    assign w_wr  = w_sel && !i_wen;
    assign w_rd  = w_sel && i_wen;
    assign w_off = i_addr[4:2];

    // ---------------------------------------------------------------- TX FIFO
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign o_tx_valid = !w_empty;
    assign w_pop      = o_tx_valid && i_tx_ready;
    assign w_push_req = w_wr && (w_off == OFF_TXDATA) && i_be[0];
    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign o_tx_data  = w_empty ? 8'h00 : r_mem[r_rptr];

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_di[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push)
                r_ovf <= 1'b1;
            else if (w_wr && (w_off == OFF_STATUS) && i_be[0] && i_di[2])
                r_ovf <= 1'b0;
        end
    end

    assign w_count8 = 8'(r_count);
    assign w_status = {16'h0000, w_count8, 5'b00000, r_ovf, w_empty, w_full};

    // ------------------------------------------------------- TOHOST / SCRATCH
    assign w_tohost_nxt  = f_merge(r_tohost, i_di, i_be);
    assign w_scratch_nxt = f_merge(r_scratch, i_di, i_be);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tohost    <= '0;
            r_scratch   <= '0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
        end else begin
            if (w_wr && (w_off == OFF_TOHOST)) begin
                r_tohost <= w_tohost_nxt;
                // Only the first halting write defines the exit code.
                if (w_tohost_nxt[0] && !r_halt) begin
                    r_halt      <= 1'b1;
                    r_halt_code <= w_tohost_nxt[31:1];
                end
            end
            if (w_wr && (w_off == OFF_SCRATCH)) r_scratch <= w_scratch_nxt;
        end
    end

    assign o_halt      = r_halt;
    assign o_halt_code = r_halt_code;

    // ----------------------------------------------------------- cycle counter
`ifdef MMIO_CYCLE_CNT_EN
    logic [63:0] r_cnt;
    logic [31:0] r_hi_snap;

    // Snapshotting the high word on the low-word read gives a tear-free 64-bit pair.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_hi_snap <= '0;
        end else begin
            if (!r_halt) r_cnt <= r_cnt + 64'd1;
            if (w_rd && (w_off == OFF_CYC_LO)) r_hi_snap <= r_cnt[63:32];
        end
    end

    assign w_cyc_lo = r_cnt[31:0];
    assign w_cyc_hi = r_hi_snap;
`else
    assign w_cyc_lo = 32'h0000_0000;
    assign w_cyc_hi = 32'h0000_0000;
`endif

    // ------------------------------------------------------------- read path
    always_comb begin
        w_rdata = 32'h0000_0000;
        case (w_off)
            OFF_STATUS:  w_rdata = w_status;
            OFF_CYC_LO:  w_rdata = w_cyc_lo;
            OFF_CYC_HI:  w_rdata = w_cyc_hi;
            OFF_TOHOST:  w_rdata = r_tohost;
            OFF_SCRATCH: w_rdata = r_scratch;
            default:     w_rdata = 32'h0000_0000;
        endcase
    end

    // DOUT is forced to 0 off-window so the bench can OR/mux it with SRAM data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout <= '0;
            r_hit  <= 1'b0;
        end else begin
            r_dout <= w_rd ? w_rdata : 32'h0000_0000;
            r_hit  <= w_sel;
        end
    end

    assign o_dout = r_dout;
    assign o_hit  = r_hit;

endmodule

// File: tb/tb_mmio_console_resp.sv
// Scoreboard bench for mmio_console_resp: read data and TX bytes are queued at stimulus time and checked on output.
module tb_mmio_console_resp;

    localparam logic [31:0] BASE = 32'h0000_3F00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csn = 1'b1;
    logic        wen = 1'b1;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] di = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] dout;
    logic        hit;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        halt;
    logic [30:0] halt_code;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] q_rd [$];
    logic [7:0]  q_tx [$];
    logic        hit_due;
    logic        rd_due;
    logic        halt_m;
    logic [31:0] tohost_m;
    logic [63:0] cnt_m;
    logic [31:0] hi_exp;

    mmio_console_resp dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_csn       (csn),
        .i_wen       (wen),
        .i_be        (be),
        .i_addr      (addr),
        .i_di        (di),
        .o_dout      (dout),
        .o_hit       (hit),
        .o_tx_valid  (tx_valid),
        .o_tx_data   (tx_data),
        .i_tx_ready  (tx_ready),
        .o_halt      (halt),
        .o_halt_code (halt_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    wire        sel_m = !csn && (addr[31:5] == BASE[31:5]);
    wire [31:0] tohost_nx = {be[3] ? di[31:24] : tohost_m[31:24],
                             be[2] ? di[23:16] : tohost_m[23:16],
                             be[1] ? di[15:8]  : tohost_m[15:8],
                             be[0] ? di[7:0]   : tohost_m[7:0]};

    // Reference model, advanced on every active edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_due  <= 1'b0;
            rd_due   <= 1'b0;
            halt_m   <= 1'b0;
            tohost_m <= '0;
            cnt_m    <= '0;
            q_rd.delete();
            q_tx.delete();
        end else begin
            hit_due <= sel_m;
            rd_due  <= sel_m && wen;
            if (!halt_m) cnt_m <= cnt_m + 64'd1;
            if (q_tx.size() != 0 && tx_ready) void'(q_tx.pop_front());
            if (sel_m && !wen && addr[4:2] == 3'd0 && be[0] && q_tx.size() < 16)
                q_tx.push_back(di[7:0]);
            if (sel_m && !wen && addr[4:2] == 3'd4) begin
                tohost_m <= tohost_nx;
                if (tohost_nx[0]) halt_m <= 1'b1;
            end
        end
    end

    // Output monitor, away from the active edge.
    always @(negedge clk) begin
        chk("hit", {63'd0, hit}, {63'd0, hit_due});
        if (rd_due) begin
            if (q_rd.size() == 0) chk("rd_queue", 64'(q_rd.size()), 64'd1);
            else chk("dout", {32'd0, dout}, {32'd0, q_rd.pop_front()});
        end else begin
            chk("dout_idle", {32'd0, dout}, 64'd0);
        end
        chk("tx_valid", {63'd0, tx_valid}, {63'd0, q_tx.size() != 0});
        if (q_tx.size() != 0) chk("tx_data", {56'd0, tx_data}, {56'd0, q_tx[0]});
    end

    task automatic drive(input logic c, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        csn = c; wen = w; be = b; addr = a; di = d;
    endtask

    task automatic wr(input logic [4:0] off, input logic [31:0] d, input logic [3:0] b);
        drive(1'b0, 1'b0, b, BASE + {27'd0, off}, d);
    endtask

    task automatic rd(input logic [4:0] off, input logic [31:0] exp);
        drive(1'b0, 1'b1, 4'h0, BASE + {27'd0, off}, 32'h0);
        q_rd.push_back(exp);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b1, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dout", {32'd0, dout}, 64'd0);
        chk("rst_hit", {63'd0, hit}, 64'd0);
        chk("rst_txv", {63'd0, tx_valid}, 64'd0);
        chk("rst_txd", {56'd0, tx_data}, 64'd0);
        chk("rst_halt", {63'd0, halt}, 64'd0);
        chk("rst_code", {33'd0, halt_code}, 64'd0);
        rst_n = 1'b1;
        rd(5'h04, 32'h0000_0002);
        idle(1);

        // push two bytes with the sink stalled, then drain
        wr(5'h00, 32'h0000_0048, 4'b0001);
        wr(5'h00, 32'h0000_0069, 4'b0001);
        rd(5'h04, 32'h0000_0200);
        idle(1);
        chk("head0", {56'd0, tx_data}, 64'h48);
        tx_ready = 1'b1;
        idle(1);
        chk("head1", {56'd0, tx_data}, 64'h69);
        idle(1);
        chk("drained", {63'd0, tx_valid}, 64'd0);
        tx_ready = 1'b0;

        // scratch byte enables
        wr(5'h14, 32'hDEAD_BEEF, 4'b1111);
        wr(5'h14, 32'h0000_0011, 4'b0001);
        rd(5'h14, 32'hDEAD_BE11);

        // decode: off-window and unused offsets change nothing
        drive(1'b0, 1'b0, 4'hF, 32'h0000_4014, 32'h1234_5678);
        drive(1'b0, 1'b0, 4'h1, 32'h0000_3EE0, 32'h0000_0055);
        wr(5'h18, 32'hFFFF_FFFF, 4'hF);
        wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
        rd(5'h18, 32'h0);
        rd(5'h1C, 32'h0);
        drive(1'b0, 1'b1, 4'h0, 32'h4000_3F14, 32'h0);
        rd(5'h14, 32'hDEAD_BE11);
        rd(5'h04, 32'h0000_0002);
        rd(5'h00, 32'h0);
        idle(1);

        // overflow: 17 pushes into 16 entries
        for (int i = 0; i < 17; i++) wr(5'h00, 32'h30 + 32'(i), 4'b0001);
        rd(5'h04, 32'h0000_1005);
        wr(5'h04, 32'h0000_0004, 4'b0001);
        rd(5'h04, 32'h0000_1001);
        wr(5'h00, 32'h0000_00AA, 4'b0001);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        rd(5'h04, 32'h0000_1001);
        idle(1);
        tx_ready = 1'b1;
        idle(20);
        tx_ready = 1'b0;
        chk("ovf_drained", {63'd0, tx_valid}, 64'd0);

        // cycle counter before halt
`ifdef MMIO_CYCLE_CNT_EN
        idle(1);
        hi_exp = cnt_m[63:32];
        rd(5'h08, cnt_m[31:0]);
        rd(5'h0C, hi_exp);
`else
        rd(5'h08, 32'h0);
        rd(5'h0C, 32'h0);
`endif

        // halt
        wr(5'h10, 32'h0000_0007, 4'b0001);
        idle(1);
        chk("halt", {63'd0, halt}, 64'd1);
        chk("halt_code", {33'd0, halt_code}, 64'd3);
        wr(5'h10, 32'h0000_0009, 4'b1111);
        rd(5'h10, 32'h0000_0009);
        idle(1);
        chk("halt_sticky", {63'd0, halt}, 64'd1);
        chk("halt_code_kept", {33'd0, halt_code}, 64'd3);

`ifdef MMIO_CYCLE_CNT_EN
        rd(5'h08, cnt_m[31:0]);
        idle(5);
        rd(5'h08, cnt_m[31:0]);
`else
        rd(5'h08, 32'h0);
        rd(5'h0C, 32'h0);
`endif
        idle(1);

        // reset in the middle of activity
        wr(5'h00, 32'h0000_0077, 4'b0001);
        rd(5'h14, 32'hDEAD_BE11);
        #2;
        rst_n = 1'b0;
        csn = 1'b1; wen = 1'b1; be = 4'h0; addr = '0; di = '0;
        #1;
        chk("mid_rst_dout", {32'd0, dout}, 64'd0);
        chk("mid_rst_hit", {63'd0, hit}, 64'd0);
        chk("mid_rst_txv", {63'd0, tx_valid}, 64'd0);
        chk("mid_rst_halt", {63'd0, halt}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        rd(5'h04, 32'h0000_0002);
        rd(5'h14, 32'h0);
        rd(5'h10, 32'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
